// File: rtl/sdes_round_ctrl.sv
// sdes_round_ctrl: sequences one S-DES encryption or decryption through a
// single shared F-function datapath (E/P, key XOR, sbox, P4), one round per
// clock. Key generation happens at accept time. The result is returned on a
// valid/ready handshake.
module sdes_round_ctrl #(
  parameter logic BACK2BACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
  input  logic       in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ROUND1, ROUND2, DONE} state_t;

  // Bit i of a permutation table (S-DES numbering, 1 = MSB) is vector bit [n-i].
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] y);
    return {y[4], y[7], y[3], y[6], y[2], y[5], y[0], y[1]};
  endfunction

  function automatic logic [4:0] ls1(input logic [4:0] x);
    return {x[3:0], x[4]};
  endfunction

  function automatic logic [4:0] ls2(input logic [4:0] x);
    return {x[2:0], x[4:3]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  state_t     state;
  logic [3:0] l_half;
  logic [3:0] r_half;
  logic [7:0] ka;
  logic [7:0] kb;

  logic [9:0] p10_key;
  logic [4:0] ls1_l;
  logic [4:0] ls1_r;
  logic [7:0] k1;
  logic [7:0] k2;
  logic [7:0] round_key;
  logic [7:0] sbox_in;
  logic [3:0] sbox_out;
  logic [3:0] f_out;
  logic       accept;

  // Key schedule from the presented key; only captured when a block is accepted.
  always_comb begin
    p10_key = p10(in_key);
    ls1_l   = ls1(p10_key[9:5]);
    ls1_r   = ls1(p10_key[4:0]);
    k1      = p8({ls1_l, ls1_r});
    k2      = p8({ls2(ls1_l), ls2(ls1_r)});
  end

  // Shared F-function front end: ROUND1 uses ka, every other state uses kb.
  always_comb begin
    round_key = (state == ROUND1) ? ka : kb;
    sbox_in   = ep(r_half) ^ round_key;
    f_out     = p4(sbox_out);
  end

  sdes_sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Input side is open in IDLE, or in DONE while the result is being taken.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == IDLE) || (BACK2BACK && (state == DONE) && out_ready);
    end
    accept = in_valid && in_ready;
  end

  // Round sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      l_half    <= 4'h0;
      r_half    <= 4'h0;
      ka        <= 8'h00;
      kb        <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
    end else if (accept) begin
      {l_half, r_half} <= ip(in_data);
      ka        <= in_mode ? k2 : k1;
      kb        <= in_mode ? k1 : k2;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      state     <= ROUND1;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
        end
        ROUND1: begin
          l_half <= r_half;
          r_half <= l_half ^ f_out;
          state  <= ROUND2;
        end
        ROUND2: begin
          out_data  <= ip_inv({l_half ^ f_out, r_half});
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// sdes_sbox: S0 on byte bits 7..4, S1 on bits 3..0. For each nibble the row
// is S-DES bits 1 and 4, the column bits 2 and 3.
module sdes_sbox (
  input  logic [7:0] din,
  output logic [3:0] dout
);

  function automatic logic [1:0] s0_lookup(input logic [3:0] idx);
    logic [1:0] v;
    v = 2'd0;
    case (idx)
      4'd0:  v = 2'd1;
      4'd1:  v = 2'd0;
      4'd2:  v = 2'd3;
      4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;
      4'd5:  v = 2'd2;
      4'd6:  v = 2'd1;
      4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;
      4'd9:  v = 2'd2;
      4'd10: v = 2'd1;
      4'd11: v = 2'd3;
      4'd12: v = 2'd3;
      4'd13: v = 2'd1;
      4'd14: v = 2'd3;
      4'd15: v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] s1_lookup(input logic [3:0] idx);
    logic [1:0] v;
    v = 2'd0;
    case (idx)
      4'd0:  v = 2'd0;
      4'd1:  v = 2'd1;
      4'd2:  v = 2'd2;
      4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;
      4'd5:  v = 2'd0;
      4'd6:  v = 2'd1;
      4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;
      4'd9:  v = 2'd0;
      4'd10: v = 2'd1;
      4'd11: v = 2'd0;
      4'd12: v = 2'd2;
      4'd13: v = 2'd1;
      4'd14: v = 2'd0;
      4'd15: v = 2'd3;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // Index each table by {row, col}.
  always_comb begin
    dout = {s0_lookup({din[7], din[4], din[6], din[5]}),
            s1_lookup({din[3], din[0], din[2], din[1]})};
  end

endmodule

// File: tb/tb_sdes_round_ctrl.sv
// tb_sdes_round_ctrl: directed vector table, hand-written handshake corner
// sequences and a randomised round trip against a table-based S-DES model.
// A second instance with BACK2BACK = 0 covers the non-overlapped DONE exit.
module tb_sdes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [9:0] in_key = 10'h000;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic       in_ready0, out_valid0, busy0;
  logic [7:0] out_data0;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] CKEY = 10'b1010000010;

  localparam int P10 = 0;
  localparam int P8  = 1;
  localparam int IP  = 2;
  localparam int IPI = 3;
  localparam int EP  = 4;
  localparam int P4  = 5;

  int ptab [6][10];
  int s0m [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1m [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  typedef struct packed {
    logic [9:0] key;
    logic [7:0] data;
    logic       mode;
    logic [7:0] result;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  sdes_round_ctrl #(.BACK2BACK(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  sdes_round_ctrl #(.BACK2BACK(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_mode   (in_mode),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .busy      (busy0)
  );

  // Generic table permutation: output bit j (1 = MSB) takes input bit ptab[sel][j].
  function automatic logic [9:0] permute(input logic [9:0] v, input int nin, input int nout,
                                         input int sel);
    logic [9:0] r;
    r = '0;
    for (int j = 0; j < nout; j++) r[nout-1-j] = v[nin-ptab[sel][j]];
    return r;
  endfunction

  function automatic logic [4:0] rotl(input logic [4:0] x, input int n);
    logic [4:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[3:0], r[4]};
    return r;
  endfunction

  function automatic logic [3:0] fModel(input logic [3:0] r, input logic [7:0] k);
    logic [9:0] e;
    logic [9:0] p;
    logic [7:0] x;
    int s0, s1;
    e  = permute({6'b0, r}, 4, 8, EP);
    x  = e[7:0] ^ k;
    s0 = s0m[{x[7], x[4]}][{x[6], x[5]}];
    s1 = s1m[{x[3], x[0]}][{x[2], x[1]}];
    p  = permute({6'b0, 2'(s0), 2'(s1)}, 4, 4, P4);
    return p[3:0];
  endfunction

  function automatic logic [7:0] sdesModel(input logic [9:0] key, input logic [7:0] data,
                                           input logic mode);
    logic [9:0] t;
    logic [4:0] a, b;
    logic [7:0] k1, k2, kx, ky;
    logic [3:0] l, r, nl;
    t  = permute(key, 10, 10, P10);
    a  = rotl(t[9:5], 1);
    b  = rotl(t[4:0], 1);
    t  = permute({a, b}, 10, 8, P8);
    k1 = t[7:0];
    t  = permute({rotl(a, 2), rotl(b, 2)}, 10, 8, P8);
    k2 = t[7:0];
    kx = mode ? k2 : k1;
    ky = mode ? k1 : k2;
    t  = permute({2'b0, data}, 8, 8, IP);
    l  = t[7:4];
    r  = t[3:0];
    nl = r;
    r  = l ^ fModel(r, kx);
    l  = nl;
    l  = l ^ fModel(r, ky);
    t  = permute({2'b0, l, r}, 8, 8, IPI);
    return t[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [9:0] k, input logic [7:0] d, input logic m);
    int w;
    w = 0;
    in_key = k;
    in_data = d;
    in_mode = m;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    int w;
    w = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(out_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] rkey;
    logic [7:0] rdata, rexp;

    ptab[P10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    ptab[P8]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    ptab[IP]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    ptab[IPI] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    ptab[EP]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    ptab[P4]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};

    vecs[0] = '{CKEY,          8'b10010111, 1'b0, 8'b00111000};
    vecs[1] = '{CKEY,          8'b00111000, 1'b1, 8'b10010111};
    vecs[2] = '{10'b0000000000, 8'b10101010, 1'b0, 8'b00010001};
    vecs[3] = '{10'b0000000000, 8'b00010001, 1'b1, 8'b10101010};
    vecs[4] = '{10'b1110001110, 8'b10101010, 1'b0, 8'b11001010};
    vecs[5] = '{10'b1110001110, 8'b11001010, 1'b1, 8'b10101010};
    vecs[6] = '{10'b1110001110, 8'b01010101, 1'b0, 8'b01110000};
    vecs[7] = '{10'b1110001110, 8'b01110000, 1'b1, 8'b01010101};
    vecs[8] = '{10'b1111111111, 8'b10101010, 1'b0, 8'b00000100};
    vecs[9] = '{10'b1111111111, 8'b00000100, 1'b1, 8'b10101010};

    $display("[TB] reset state");
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ka", 32'(dut.ka), 32'h00);
    check("rst_kb", 32'(dut.kb), 32'h00);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] classic encrypt with latency");
    out_ready = 1'b1;
    applyStimulus(CKEY, 8'b10010111, 1'b0);
    check("enc_k1", 32'(dut.ka), 32'b10100100);
    check("enc_k2", 32'(dut.kb), 32'b01000011);
    check("r1_busy", 32'(busy), 32'd1);
    check("r1_out_valid", 32'(out_valid), 32'd0);
    check("r1_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("r2_out_valid", 32'(out_valid), 32'd0);
    check("r2_busy", 32'(busy), 32'd1);
    check("r2_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_out_data", 32'(out_data), 32'b00111000);
    check("done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] classic decrypt");
    applyStimulus(CKEY, 8'b00111000, 1'b1);
    check("dec_ka", 32'(dut.ka), 32'b01000011);
    check("dec_kb", 32'(dut.kb), 32'b10100100);
    checkOutput("dec_classic", 8'b10010111);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].key, vecs[i].data, vecs[i].mode);
      checkOutput($sformatf("vec%0d", i), vecs[i].result);
    end

    $display("[TB] backpressure and DONE exit");
    doReset();
    out_ready = 1'b0;
    applyStimulus(CKEY, 8'b10010111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'b00111000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid_nb2b", 32'(out_valid0), 32'd1);
      check("bp_in_ready_nb2b", 32'(in_ready0), 32'd0);
      @(posedge clk); #1;
    end
    in_key = CKEY;
    in_data = 8'b00111000;
    in_mode = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    check("nb2b_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    check("b2b_out_valid_drop", 32'(out_valid), 32'd0);
    check("nb2b_idle_busy", 32'(busy0), 32'd0);
    check("nb2b_idle_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    check("nb2b_accepted_busy", 32'(busy0), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_result_valid", 32'(out_valid), 32'd1);
    check("b2b_result_data", 32'(out_data), 32'b10010111);
    @(posedge clk); #1;
    check("b2b_result_taken", 32'(out_valid), 32'd0);
    check("nb2b_result_valid", 32'(out_valid0), 32'd1);
    check("nb2b_result_data", 32'(out_data0), 32'b10010111);
    @(posedge clk); #1;
    check("nb2b_result_taken", 32'(out_valid0), 32'd0);

    $display("[TB] busy rejection");
    doReset();
    out_ready = 1'b1;
    applyStimulus(CKEY, 8'b10010111, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h55;
    in_mode = 1'b1;
    in_key = 10'h3FF;
    #1;
    check("rej_in_ready_r1", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_data = 8'hAA;
    check("rej_in_ready_r2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rej_out_valid", 32'(out_valid), 32'd1);
    check("rej_out_data", 32'(out_data), 32'b00111000);
    @(posedge clk); #1;
    check("rej_taken", 32'(out_valid), 32'd0);
    check("rej_no_extra_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("rej_still_idle", 32'(busy), 32'd0);

    $display("[TB] reset during ROUND2");
    applyStimulus(CKEY, 8'b10010111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rr_out_valid", 32'(out_valid), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rr_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rr_no_output", 32'(out_valid), 32'd0);
    end
    applyStimulus(CKEY, 8'b10010111, 1'b0);
    checkOutput("rr_next_enc", 8'b00111000);

    $display("[TB] random round trip");
    for (int i = 0; i < 200; i++) begin
      rkey  = 10'($urandom_range(0, 1023));
      rdata = 8'($urandom_range(0, 255));
      rexp  = sdesModel(rkey, rdata, 1'b0);
      applyStimulus(rkey, rdata, 1'b0);
      checkOutput("rnd_enc", rexp);
      applyStimulus(rkey, rexp, 1'b1);
      checkOutput("rnd_dec", rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
